// File: rtl/seq_divider32by16.sv
// seq_divider32by16: sequential restoring divider, 2*DVS_W-bit dividend by
// DVS_W-bit divisor, with start/busy/done handshake.
// Optional build macro: DIV_RADIX4_EN chains two restoring steps per clock
// (16 CALC cycles instead of 32); results are bit-identical either way.
module seq_divider32by16 #(
   parameter int DVS_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [2*DVS_W-1:0]   Dividend,
   input  logic [DVS_W-1:0]     Divisor,
   output logic                 busy,
   output logic                 done,
   output logic [2*DVS_W-1:0]   Quot,
   output logic [DVS_W-1:0]     Rem,
   output logic                 div_zero
);

   localparam int DVD_W = 2 * DVS_W;
   localparam int CNT_W = $clog2(DVD_W);
`ifdef DIV_RADIX4_EN
   localparam int ITERS = DVD_W / 2;
`else
   localparam int ITERS = DVD_W;
`endif
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

   typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DVD_W-1:0]   dvd_q, dvd_d;   // dividend shifts out the top, quotient bits enter the bottom
   logic [DVS_W-1:0]   dvs_q, dvs_d;
   logic [DVS_W-1:0]   p_q, p_d;       // partial remainder; always < divisor so DVS_W bits suffice
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [DVD_W-1:0]   quot_q, quot_d;
   logic [DVS_W-1:0]   rem_q, rem_d;
   logic               dz_q, dz_d;

   logic [DVS_W+DVD_W-1:0] step_res;

   // One restoring step: returns {new partial remainder, shifted dividend/quotient word}.
   function automatic logic [DVS_W+DVD_W-1:0] div_step(
      input logic [DVS_W-1:0] p,
      input logic [DVD_W-1:0] w,
      input logic [DVS_W-1:0] d
   );
      logic [DVS_W:0]   ps;
      logic [DVS_W-1:0] nr;
      logic             q;
      ps = {p, w[DVD_W-1]};
      q  = (ps >= {1'b0, d});
      nr = q ? DVS_W'(ps - {1'b0, d}) : ps[DVS_W-1:0];
      return {nr, w[DVD_W-2:0], q};
   endfunction

   // Datapath for one CALC clock: one step, or two chained steps in the radix-4 build.
   always_comb begin
`ifdef DIV_RADIX4_EN
      logic [DVS_W+DVD_W-1:0] s1;
      s1       = div_step(p_q, dvd_q, dvs_q);
      step_res = div_step(s1[DVS_W+DVD_W-1:DVD_W], s1[DVD_W-1:0], dvs_q);
`else
      step_res = div_step(p_q, dvd_q, dvs_q);
`endif
   end

   // Next-state and output logic; results only move on the FINISH->IDLE edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      p_d     = p_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dz_d    = dz_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               dvd_d   = Dividend;
               dvs_d   = Divisor;
               p_d     = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = (Divisor == '0) ? FINISH : CALC;
            end
         end
         CALC: begin
            p_d   = step_res[DVS_W+DVD_W-1:DVD_W];
            dvd_d = step_res[DVD_W-1:0];
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) state_d = FINISH;
         end
         FINISH: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            dz_d    = (dvs_q == '0);
            quot_d  = (dvs_q == '0) ? '1 : dvd_q;
            rem_d   = (dvs_q == '0) ? dvd_q[DVS_W-1:0] : p_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         p_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         p_q     <= p_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dz_q    <= dz_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign Quot     = quot_q;
   assign Rem      = rem_q;
   assign div_zero = dz_q;

endmodule

// File: tb/tb_seq_divider32by16.sv
// Testbench for seq_divider32by16: directed cases, ignored starts, reset
// mid-operation, back-to-back and randomized operands against an arithmetic model.
module tb_seq_divider32by16;

`ifdef DIV_RADIX4_EN
   localparam int LAT = 17;
`else
   localparam int LAT = 33;
`endif

   logic        clk, rst_n, start;
   logic [31:0] Dividend;
   logic [15:0] Divisor;
   logic        busy, done, div_zero;
   logic [31:0] Quot;
   logic [15:0] Rem;

   int nvec = 0;
   int nerr = 0;

   seq_divider32by16 dut (
      .clk(clk), .rst_n(rst_n), .start(start), .Dividend(Dividend), .Divisor(Divisor),
      .busy(busy), .done(done), .Quot(Quot), .Rem(Rem), .div_zero(div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one operation and wait (bounded) for done. Reports latency in edges
   // after the accepting edge, the results, whether busy stayed high and the
   // outputs stayed frozen while waiting, and busy in the done cycle.
   task automatic run_op(input logic [31:0] a, input logic [15:0] b, output int lat,
                         output logic [31:0] q, output logic [15:0] r, output logic dz,
                         output logic wait_ok, output logic busy_at_done);
      logic [31:0] q0;
      logic [15:0] r0;
      @(negedge clk);
      Dividend = a; Divisor = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      Dividend = $urandom; Divisor = 16'($urandom);
      q0 = Quot; r0 = Rem;
      lat = 0; wait_ok = 1'b1;
      while (!done && lat < 100) begin
         if (!busy || Quot !== q0 || Rem !== r0) wait_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      q = Quot; r = Rem; dz = div_zero; busy_at_done = busy;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; Dividend = '0; Divisor = '0;
      repeat (2) @(posedge clk);
      #1;
      nvec++;
      if ({busy, done, div_zero, Quot, Rem} !== 51'd0) begin
         nerr++;
         $display("FAIL reset_state got busy=%b done=%b dz=%b q=%h r=%h, want all 0",
                  busy, done, div_zero, Quot, Rem);
      end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [31:0] da [6] = '{32'd100, 32'hFFFF_FFFF, 32'd5, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF};
      logic [15:0] db [6] = '{16'd7, 16'hFFFF, 16'd9, 16'd0, 16'd1, 16'd1};
      logic [31:0] eq [6] = '{32'd14, 32'h0001_0001, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF};
      logic [15:0] er [6] = '{16'd2, 16'd0, 16'd5, 16'h5678, 16'd0, 16'd0};
      int lat; logic [31:0] q; logic [15:0] r; logic dz, wok, bd;
      for (int i = 0; i < 6; i++) begin
         run_op(da[i], db[i], lat, q, r, dz, wok, bd);
         nvec++;
         if (lat !== ((db[i] == 0) ? 1 : LAT)) begin
            nerr++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, (db[i] == 0) ? 1 : LAT);
         end
         nvec++;
         if (q !== eq[i] || r !== er[i] || dz !== (db[i] == 0)) begin
            nerr++; $display("FAIL dir%0d_result got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                             i, q, r, dz, eq[i], er[i], db[i] == 0);
         end
         nvec++;
         if (!wok || bd !== 1'b0) begin
            nerr++; $display("FAIL dir%0d_handshake got wait_ok=%b busy_at_done=%b want 1 0", i, wok, bd);
         end
      end
   endtask

   // Starts during CALC and during the FINISH cycle must be ignored.
   task automatic test_ignored_start();
      int ndone = 0, done_c = -1;
      logic [31:0] q = '0; logic [15:0] r = '0;
      @(negedge clk);
      Dividend = 32'd1000; Divisor = 16'd3; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      for (int c = 1; c <= 80; c++) begin
         if (c == 10 || c == LAT) begin
            @(negedge clk); start = 1'b1; Dividend = 32'd50; Divisor = 16'd5;
         end
         @(posedge clk); #1; start = 1'b0;
         if (done) begin
            ndone++;
            if (done_c < 0) begin done_c = c; q = Quot; r = Rem; end
         end
      end
      nvec++;
      if (ndone != 1 || done_c != LAT) begin
         nerr++; $display("FAIL ignored_start_done got count=%0d at=%0d want 1 at %0d", ndone, done_c, LAT);
      end
      nvec++;
      if (q !== 32'd333 || r !== 16'd1) begin
         nerr++; $display("FAIL ignored_start_result got q=%0d r=%0d want 333 1", q, r);
      end
   endtask

   task automatic test_reset_mid_op();
      int ndone = 0;
      int lat; logic [31:0] q; logic [15:0] r; logic dz, wok, bd;
      @(negedge clk);
      Dividend = 32'd1000; Divisor = 16'd3; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (12) @(posedge clk);
      @(negedge clk); rst_n = 1'b0;
      #1;
      nvec++;
      if ({busy, done, div_zero, Quot, Rem} !== 51'd0) begin
         nerr++; $display("FAIL reset_mid_op got busy=%b done=%b dz=%b q=%h r=%h, want all 0",
                          busy, done, div_zero, Quot, Rem);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (done || busy) ndone++;
      end
      nvec++;
      if (ndone != 0) begin
         nerr++; $display("FAIL reset_no_done got %0d active cycles want 0", ndone);
      end
      run_op(32'd21, 16'd4, lat, q, r, dz, wok, bd);
      nvec++;
      if (q !== 32'd5 || r !== 16'd1 || lat != LAT) begin
         nerr++; $display("FAIL after_reset_op got q=%0d r=%0d lat=%0d want 5 1 %0d", q, r, lat, LAT);
      end
   endtask

   task automatic test_back_to_back();
      int lat; logic [31:0] q; logic [15:0] r; logic dz, wok, bd;
      run_op(32'd60000, 16'd7, lat, q, r, dz, wok, bd);
      nvec++;
      if (q !== 32'd8571 || r !== 16'd3 || lat != LAT) begin
         nerr++; $display("FAIL b2b_first got q=%0d r=%0d lat=%0d want 8571 3 %0d", q, r, lat, LAT);
      end
      run_op(32'd65535, 16'd256, lat, q, r, dz, wok, bd);
      nvec++;
      if (q !== 32'd255 || r !== 16'd255 || lat != LAT) begin
         nerr++; $display("FAIL b2b_second got q=%0d r=%0d lat=%0d want 255 255 %0d", q, r, lat, LAT);
      end
   endtask

   task automatic test_random();
      int lat; logic [31:0] q, a, eq; logic [15:0] r, b, er; logic dz, wok, bd;
      logic [63:0] recon;
      for (int i = 0; i < 400; i++) begin
         a = $urandom;
         case ($urandom_range(0, 15))
            0:       b = 16'd0;
            1, 2, 3: b = 16'($urandom_range(1, 15));
            4:       b = 16'hFFFF;
            default: b = 16'($urandom);
         endcase
         if (b == 0) begin eq = 32'hFFFF_FFFF; er = a[15:0]; end
         else begin eq = a / {16'd0, b}; er = 16'(a % {16'd0, b}); end
         run_op(a, b, lat, q, r, dz, wok, bd);
         nvec++;
         if (q !== eq || r !== er || dz !== (b == 0) || lat != ((b == 0) ? 1 : LAT) || !wok || bd) begin
            nerr++;
            $display("FAIL rand%0d %h/%h got q=%h r=%h dz=%b lat=%0d wok=%b bsy=%b want q=%h r=%h lat=%0d",
                     i, a, b, q, r, dz, lat, wok, bd, eq, er, (b == 0) ? 1 : LAT);
         end
         if (b != 0) begin
            recon = {32'd0, q} * {48'd0, b} + {48'd0, r};
            nvec++;
            if (recon !== {32'd0, a} || r >= b) begin
               nerr++; $display("FAIL rand%0d_invariant got q*d+r=%h r=%h want %h r<%h", i, recon, r, a, b);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_ignored_start();
      test_reset_mid_op();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
